// File: rtl/branch_predictor.sv
// Branch prediction unit: direct-mapped BTB plus a PHT of 2-bit saturating
// counters (bimodal or gshare indexing). IF reads combinationally, EX resolves
// and trains at the clock edge, and mispredictions raise flush/redirect_pc.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   if_pc               fetch PC
//   pred_taken          predicted direction for if_pc
//   pred_target         predicted next PC (BTB target or if_pc+4)
//   pred_ghr            global history snapshot carried down the pipe
//   ex_*                resolved branch information and carried prediction
//   flush               misprediction detected in EX this cycle
//   redirect_pc         correct next PC, valid while flush=1
//   br_count            resolved branches (saturating)
//   mispred_count       flushes (saturating)
module branch_predictor #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned BTB_BITS = 6,
    parameter int unsigned PHT_BITS = 8,
    parameter int unsigned MODE     = 0,
    parameter int unsigned GHR_W    = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             ex_valid,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_is_branch,
    input  logic             ex_uncond,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_pred_target,
    input  logic [GHR_W-1:0] ex_ghr,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int unsigned BTB_N = 1 << BTB_BITS;
    localparam int unsigned PHT_N = 1 << PHT_BITS;
    localparam int unsigned TAG_W = PC_W - BTB_BITS - 2;

    logic [BTB_N-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [BTB_N];
    logic [PC_W-1:0]  tgt_q [BTB_N];
    logic [1:0]       pht_q [PHT_N];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    function automatic logic [BTB_BITS-1:0] btb_idx(input logic [PC_W-1:0] pc);
        return pc[BTB_BITS+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [PC_W-1:0] pc);
        return pc[PC_W-1:BTB_BITS+2];
    endfunction

    // Gshare folds the zero-extended history into the low PC index bits.
    function automatic logic [PHT_BITS-1:0] pht_idx(input logic [PC_W-1:0] pc,
                                                    input logic [GHR_W-1:0] ghr);
        logic [PHT_BITS-1:0] hist;
        hist = (MODE == 1) ? PHT_BITS'(ghr) : '0;
        return pc[PHT_BITS+1:2] ^ hist;
    endfunction

    // Fetch-side lookup; reads registered state so a same-cycle EX write is not visible.
    logic [BTB_BITS-1:0] if_bi;
    logic [PHT_BITS-1:0] if_pi;
    logic                if_hit;

    assign if_bi       = btb_idx(if_pc);
    assign if_pi       = pht_idx(if_pc, ghr_q);
    assign if_hit      = valid_q[if_bi] && (tag_q[if_bi] == tag_of(if_pc));
    assign pred_taken  = if_hit && pht_q[if_pi][1];
    assign pred_target = pred_taken ? tgt_q[if_bi] : if_pc + PC_W'(4);
    assign pred_ghr    = ghr_q;

    // EX-side lookup; counters are indexed with the history carried from fetch.
    logic [BTB_BITS-1:0] ex_bi;
    logic [PHT_BITS-1:0] ex_pi;
    logic                ex_hit;
    logic                ex_act;

    assign ex_bi  = btb_idx(ex_pc);
    assign ex_pi  = pht_idx(ex_pc, ex_ghr);
    assign ex_hit = valid_q[ex_bi] && (tag_q[ex_bi] == tag_of(ex_pc));
    assign ex_act = ex_valid && rst;

    // Misprediction detection and correct next PC; held at zero while in reset.
    always_comb begin
        flush       = 1'b0;
        redirect_pc = '0;
        if (ex_act) begin
            if (ex_is_branch) begin
                flush = (ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target));
            end else begin
                flush = ex_pred_taken;
            end
            redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + PC_W'(4);
        end
    end

    // Training decisions for the resolving instruction.
    logic       pht_we;
    logic [1:0] pht_wdata;
    logic [1:0] pht_cur;
    logic       btb_we;
    logic       btb_inv;

    assign pht_cur = pht_q[ex_pi];

    always_comb begin
        pht_we    = 1'b0;
        pht_wdata = pht_cur;
        btb_we    = 1'b0;
        btb_inv   = 1'b0;
        ghr_d     = ghr_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (ex_act) begin
            if (ex_is_branch) begin
                pht_we = 1'b1;
                if (ex_uncond) begin
                    pht_wdata = 2'd3;
                end else if (ex_taken && !ex_hit) begin
                    // Newly allocated branch starts weakly taken.
                    pht_wdata = 2'd2;
                end else if (ex_taken) begin
                    pht_wdata = (pht_cur == 2'd3) ? 2'd3 : pht_cur + 2'd1;
                end else begin
                    pht_wdata = (pht_cur == 2'd0) ? 2'd0 : pht_cur - 2'd1;
                end
                if (!ex_uncond) begin
                    ghr_d = GHR_W'({ghr_q, ex_taken});
                end
                btb_we = ex_taken;
                if (br_cnt_q != '1) begin
                    br_cnt_d = br_cnt_q + CNT_W'(1);
                end
            end else if (ex_pred_taken && ex_hit) begin
                // A non-branch that hit the BTB is an alias; drop the entry.
                btb_inv = 1'b1;
            end
            if (flush && (mis_cnt_q != '1)) begin
                mis_cnt_d = mis_cnt_q + CNT_W'(1);
            end
        end
    end

    // State with reset: valid bits, counters, history and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            ghr_q     <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= 2'd1;
            end
        end else begin
            ghr_q     <= ghr_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            if (pht_we) begin
                pht_q[ex_pi] <= pht_wdata;
            end
            if (btb_we) begin
                valid_q[ex_bi] <= 1'b1;
            end else if (btb_inv) begin
                valid_q[ex_bi] <= 1'b0;
            end
        end
    end

    // BTB payload; qualified by valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            tag_q[ex_bi] <= tag_of(ex_pc);
            tgt_q[ex_bi] <= ex_target;
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch prediction unit that replaces the single-bit prediction/flush path of the 5-stage RV64 pipeline.
- It has two structures: a direct-mapped BTB (tag, target, valid) indexed by PC, and a PHT of 2-bit saturating counters indexed in bimodal or gshare mode.
- IF reads the predictor combinationally. EX resolves each branch and trains the predictor at the clock edge.
- The block raises flush and redirect_pc on a misprediction and keeps branch and mispredict counters.

Parameters:
- PC_W, 32, PC width.
- BTB_BITS, 6, log2 of BTB entries.
- PHT_BITS, 8, log2 of PHT entries.
- MODE, 0, PHT indexing: 0 = bimodal, 1 = gshare.
- GHR_W, 8, global history length. Must be <= PHT_BITS; used only when MODE=1.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- if_pc  in  PC_W  PC being fetched
- pred_taken  out  1  prediction for if_pc
- pred_target  out  PC_W  next PC: BTB target if pred_taken, else if_pc+4
- pred_ghr  out  GHR_W  GHR snapshot; the pipeline carries it to EX
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction
- ex_pc  in  PC_W  PC of the EX instruction
- ex_is_branch  in  1  EX instruction is a conditional branch or jal
- ex_uncond  in  1  EX instruction is jal (always taken)
- ex_taken  in  1  resolved direction
- ex_target  in  PC_W  resolved target
- ex_pred_taken  in  1  prediction that was carried with the instruction
- ex_pred_target  in  PC_W  predicted next PC that was carried
- ex_ghr  in  GHR_W  pred_ghr that was carried
- flush  out  1  misprediction; kill IF/ID and ID/EX this cycle
- redirect_pc  out  PC_W  correct next PC, valid while flush=1
- br_count  out  CNT_W  number of resolved branches
- mispred_count  out  CNT_W  number of flushes

Behaviour:
Indexing:
- btb_idx = pc[BTB_BITS+1:2].
- tag = pc[PC_W-1:BTB_BITS+2].
- MODE=0: pht_idx = pc[PHT_BITS+1:2].
- MODE=1: pht_idx = pc[PHT_BITS+1:2] XOR zero-extended ghr. EX updates use ex_ghr, not the live GHR.

Prediction (combinational, no latency):
- hit = valid[btb_idx] && tag match.
- pred_taken = hit && pht[pht_idx][1].
- pred_target = pred_taken ? btb_target : if_pc+4.
- pred_ghr = current GHR.

Resolution (combinational on EX inputs):
- flush = ex_valid && (ex_is_branch ? (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)) : ex_pred_taken).
- redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc+4.
- Both outputs are 0 when ex_valid=0.

Update at posedge clk, only when ex_valid=1:
- Branch, conditional:
  - Counter increments if taken, decrements if not, saturating at 3 and 0.
  - GHR <= {GHR[GHR_W-2:0], ex_taken}.
- Branch, ex_uncond=1:
  - Counter set to 3.
  - GHR is not shifted.
- Branch, taken:
  - BTB writes tag, target and valid=1, allocating over any victim.
  - On a BTB miss, a conditional branch's counter is set to 2 (weakly taken), not incremented.
- Branch, not taken on a BTB miss: no allocation.
- Non-branch with ex_pred_taken=1 (alias): the matching BTB entry is invalidated. Counters are untouched.
- Counters: br_count += 1 per resolved branch; mispred_count += 1 per flush. Both saturate at all-ones and never wrap.

Read/write collision:
- Same-cycle IF read and EX write to the same entry: IF sees the old value (read-before-write).

Reset (rst=0, asynchronous):
- All valid bits cleared; all counters set to 1 (weakly not-taken); GHR = 0; statistics counters = 0.
- Outputs immediately: pred_taken=0, pred_target=if_pc+4, flush=0 (ex_valid is ignored during reset), redirect_pc=0.
- Reset asserted mid-training discards all state. The first cycle after release behaves as cold start.

Exclusions:
- No stall input; pipeline stalls are expressed by the pipeline holding ex_valid=0.

Test Plan:
- Cold start: reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104, br_count=0. No flush on any cycle with ex_valid=0.
- Loop training (MODE=0): branch at 0x40 with target 0x20.
  - Resolve taken once with ex_pred_taken=0 -> flush=1, redirect_pc=0x20, BTB allocated, counter=2.
  - Next fetch of 0x40 -> pred_taken=1, pred_target=0x20.
  - Resolve not-taken with ex_pred_taken=1 -> flush=1, redirect_pc=0x44, counter=1, pred_taken=0.
- Saturation: resolve 0x40 taken 5 times -> counter stays 3. Then 1 not-taken -> still predicts taken. A 2nd not-taken -> predicts not-taken.
- Target change and alias:
  - Same PC resolved taken to 0x80 while carrying ex_pred_target=0x20 -> flush, redirect_pc=0x80, BTB target updated.
  - Non-branch with ex_pred_taken=1 -> flush, redirect_pc=ex_pc+4, entry invalidated.
- Gshare (MODE=1, GHR_W=2): branch at 0x40 alternating T/N, with carried ex_ghr used for updates -> after training, mispred_count stops incrementing. The bimodal build of the same pattern keeps mispredicting.
- Collision and reset:
  - IF reads 0x40 in the same cycle EX updates it -> IF sees the pre-update prediction.
  - Assert rst mid-sequence -> pred_taken=0, mispred_count=0 asynchronously, and both stay so after release.
